// File: rtl/id_ex_stage_pkg.sv
// Shared rv32i decode/execute constants and the register-address type.
// No logic; imported by the pipeline register, its bypass mux and the port interface.
package id_ex_stage_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;
    localparam int CNT_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/registerfile/writeback/execute signals of the ID->EX pipeline register.
// master = surrounding pipeline, slave = the stage itself.
interface id_ex_stage_if #(
    parameter int XLEN   = id_ex_stage_pkg::XLEN,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int CNT_W  = id_ex_stage_pkg::CNT_W
);
    import id_ex_stage_pkg::*;

    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    reg_addr_t         id_rs1;
    reg_addr_t         id_rs2;
    reg_addr_t         id_rd;
    logic [XLEN-1:0]   id_imm;
    logic              id_mem_read;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rf_op_a;
    logic [XLEN-1:0]   rf_op_b;
    logic              wb_en;
    reg_addr_t         wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    reg_addr_t         ex_rs1;
    reg_addr_t         ex_rs2;
    reg_addr_t         ex_rd;
    logic [XLEN-1:0]   ex_op_a;
    logic [XLEN-1:0]   ex_op_b;
    logic              ex_mem_read;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_mem_read, id_ctrl,
        output rf_op_a, rf_op_b, wb_en, wb_rd, wb_data, flush, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
        input  ex_op_a, ex_op_b, ex_mem_read, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_imm, id_mem_read, id_ctrl,
        input  rf_op_a, rf_op_b, wb_en, wb_rd, wb_data, flush, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
        output ex_op_a, ex_op_b, ex_mem_read, ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// Operand select: x0 reads as zero, a matching writeback this cycle wins over the stored value.
// Purely combinational; no latency, no backpressure.
module operand_bypass #(
    parameter int XLEN = id_ex_stage_pkg::XLEN
) (
    input  id_ex_stage_pkg::reg_addr_t rs_i,
    input  logic [XLEN-1:0]            rf_val_i,
    input  logic                       wb_en_i,
    input  id_ex_stage_pkg::reg_addr_t wb_rd_i,
    input  logic [XLEN-1:0]            wb_data_i,
    output logic [XLEN-1:0]            op_o
);
    always_comb begin
        op_o = rf_val_i;
        if (rs_i == id_ex_stage_pkg::REG_ZERO) begin
            op_o = '0;
        end else if (wb_en_i && (wb_rd_i == rs_i)) begin
            op_o = wb_data_i;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with writeback bypass, load-use bubble insertion and flush; latency 1 cycle.
// Backpressure: id_ready drops while EX is stalled or a load-use hazard exists; held operands track writeback.
module id_ex_stage #(
    parameter int XLEN   = id_ex_stage_pkg::XLEN,
    parameter int CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int CNT_W  = id_ex_stage_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    import id_ex_stage_pkg::*;

    logic              ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
    reg_addr_t         ex_rs1_q,      ex_rs1_d;
    reg_addr_t         ex_rs2_q,      ex_rs2_d;
    reg_addr_t         ex_rd_q,       ex_rd_d;
    logic [XLEN-1:0]   ex_op_a_q,     ex_op_a_d;
    logic [XLEN-1:0]   ex_op_b_q,     ex_op_b_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q,  bubble_cnt_d;

    logic              hz;
    logic              slot_free;
    logic [XLEN-1:0]   cap_op_a, cap_op_b, hold_op_a, hold_op_b;

    // A load in EX cannot forward to a dependent instruction in the same cycle.
    assign hz = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != REG_ZERO)
              & ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
    assign slot_free    = !ex_valid_q | bus.ex_ready;
    assign bus.id_ready = slot_free & !hz;

    operand_bypass #(.XLEN(XLEN)) u_cap_a (
        .rs_i(bus.id_rs1), .rf_val_i(bus.rf_op_a), .wb_en_i(bus.wb_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .op_o(cap_op_a)
    );
    operand_bypass #(.XLEN(XLEN)) u_cap_b (
        .rs_i(bus.id_rs2), .rf_val_i(bus.rf_op_b), .wb_en_i(bus.wb_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .op_o(cap_op_b)
    );
    operand_bypass #(.XLEN(XLEN)) u_hold_a (
        .rs_i(ex_rs1_q), .rf_val_i(ex_op_a_q), .wb_en_i(bus.wb_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .op_o(hold_op_a)
    );
    operand_bypass #(.XLEN(XLEN)) u_hold_b (
        .rs_i(ex_rs2_q), .rf_val_i(ex_op_b_q), .wb_en_i(bus.wb_en),
        .wb_rd_i(bus.wb_rd), .wb_data_i(bus.wb_data), .op_o(hold_op_b)
    );

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_imm_d      = ex_imm_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rd_d       = ex_rd_q;
        ex_op_a_d     = hold_op_a;
        ex_op_b_d     = hold_op_b;
        ex_mem_read_d = ex_mem_read_q;
        ex_ctrl_d     = ex_ctrl_q;
        bubble_cnt_d  = bubble_cnt_q;

        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (!slot_free) begin
            ex_valid_d = 1'b1;
        end else if (hz) begin
            ex_valid_d = 1'b0;
            if (!(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (bus.id_valid) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = bus.id_pc;
            ex_imm_d      = bus.id_imm;
            ex_rs1_d      = bus.id_rs1;
            ex_rs2_d      = bus.id_rs2;
            ex_rd_d       = bus.id_rd;
            ex_op_a_d     = cap_op_a;
            ex_op_b_d     = cap_op_b;
            ex_mem_read_d = bus.id_mem_read;
            ex_ctrl_d     = bus.id_ctrl;
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_imm_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_op_a_q     <= '0;
            ex_op_b_q     <= '0;
            ex_mem_read_q <= 1'b0;
            ex_ctrl_q     <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_imm_q      <= ex_imm_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rd_q       <= ex_rd_d;
            ex_op_a_q     <= ex_op_a_d;
            ex_op_b_q     <= ex_op_b_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_ctrl_q     <= ex_ctrl_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs1      = ex_rs1_q;
    assign bus.ex_rs2      = ex_rs2_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_op_a     = ex_op_a_q;
    assign bus.ex_op_b     = ex_op_b_q;
    assign bus.ex_mem_read = ex_mem_read_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: bypass vector table, scoreboard on EX consumption, hand sequences for stalls.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] op_a;
        logic [31:0] op_b;
        reg_addr_t   rs1;
        reg_addr_t   rs2;
        reg_addr_t   rd;
        logic        mem_read;
        logic [15:0] ctrl;
    } tr_t;

    typedef struct {
        reg_addr_t   rs1;
        reg_addr_t   rs2;
        logic [31:0] rf_a;
        logic [31:0] rf_b;
        logic        wb_en;
        reg_addr_t   wb_rd;
        logic [31:0] wb_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    tr_t  sb_q[$];
    tr_t  sb_exp;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic tr_t observe();
        tr_t t;
        t.pc = bus.ex_pc;        t.imm = bus.ex_imm;
        t.op_a = bus.ex_op_a;    t.op_b = bus.ex_op_b;
        t.rs1 = bus.ex_rs1;      t.rs2 = bus.ex_rs2;     t.rd = bus.ex_rd;
        t.mem_read = bus.ex_mem_read;  t.ctrl = bus.ex_ctrl;
        return t;
    endfunction

    function automatic tr_t mk(input logic [31:0] pc, input reg_addr_t rs1, input reg_addr_t rs2,
                               input reg_addr_t rd, input logic mr,
                               input logic [31:0] op_a, input logic [31:0] op_b);
        tr_t t;
        t.pc = pc;  t.imm = pc ^ 32'h5A5A_0000;
        t.op_a = op_a;  t.op_b = op_b;
        t.rs1 = rs1;  t.rs2 = rs2;  t.rd = rd;
        t.mem_read = mr;  t.ctrl = pc[15:0] ^ 16'h3C3C;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.id_valid = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
    endtask

    task automatic issue(input tr_t t, input logic [31:0] rf_a, input logic [31:0] rf_b, input bit push);
        bus.id_valid    = 1'b1;
        bus.id_pc       = t.pc;
        bus.id_imm      = t.imm;
        bus.id_rs1      = t.rs1;
        bus.id_rs2      = t.rs2;
        bus.id_rd       = t.rd;
        bus.id_mem_read = t.mem_read;
        bus.id_ctrl     = t.ctrl;
        bus.rf_op_a     = rf_a;
        bus.rf_op_b     = rf_b;
        if (push) sb_q.push_back(t);
    endtask

    task automatic wb(input logic en, input reg_addr_t rd, input logic [31:0] d);
        bus.wb_en = en;  bus.wb_rd = rd;  bus.wb_data = d;
    endtask

    // Every cycle EX hands an instruction onward it must be the oldest one expected.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %0h expected no instruction", bus.ex_pc);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_tr", observe(), sb_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        //         rs1    rs2    rf_a        rf_b        wb  wb_rd  wb_data     exp_a       exp_b
        vt[0] = '{5'd5, 5'd3, 32'h11,     32'h22,     1, 5'd5, 32'hAB,     32'hAB,     32'h22};
        vt[1] = '{5'd0, 5'd4, 32'h11,     32'h33,     1, 5'd5, 32'hAB,     32'h0,      32'h33};
        vt[2] = '{5'd6, 5'd7, 32'h66,     32'h77,     0, 5'd6, 32'hBAD,    32'h66,     32'h77};
        vt[3] = '{5'd8, 5'd9, 32'h88,     32'h99,     1, 5'd9, 32'hC0DE,   32'h88,     32'hC0DE};
        vt[4] = '{5'd12, 5'd12, 32'h1,    32'h2,      1, 5'd12, 32'hFACE,  32'hFACE,   32'hFACE};
        vt[5] = '{5'd0, 5'd0, 32'hFFFF,   32'hEEEE,   1, 5'd0, 32'h1234,   32'h0,      32'h0};
        vt[6] = '{5'd13, 5'd14, 32'hD,    32'hE,      1, 5'd15, 32'hF00,   32'hD,      32'hE};

        // Reset with random inputs: everything reads zero.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.id_valid = 1'($urandom);     bus.id_pc = $urandom;     bus.id_imm = $urandom;
            bus.id_rs1 = 5'($urandom);       bus.id_rs2 = 5'($urandom); bus.id_rd = 5'($urandom);
            bus.id_mem_read = 1'($urandom);  bus.id_ctrl = 16'($urandom);
            bus.rf_op_a = $urandom;          bus.rf_op_b = $urandom;
            bus.wb_en = 1'($urandom);        bus.wb_rd = 5'($urandom); bus.wb_data = $urandom;
            bus.flush = 1'($urandom);        bus.ex_ready = 1'($urandom);
            tick();
        end
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_fields", observe(), 0);
        chk("rst_bubble", bus.bubble_cnt, 0);
        rst = 1'b0;
        idle_in();
        tick();

        // Capture-time bypass table.
        for (int i = 0; i < 7; i++) begin
            wb(vt[i].wb_en, vt[i].wb_rd, vt[i].wb_data);
            issue(mk(32'h1000 + 32'(i) * 4, vt[i].rs1, vt[i].rs2, 5'(i + 10), 1'b0,
                     vt[i].exp_a, vt[i].exp_b), vt[i].rf_a, vt[i].rf_b, 1'b1);
            tick();
            chk("vec_op_a", bus.ex_op_a, vt[i].exp_a);
            chk("vec_op_b", bus.ex_op_b, vt[i].exp_b);
            idle_in();
            tick();
        end

        // Load-use: one bubble, then the dependent instruction goes in.
        issue(mk(32'h3000, 5'd1, 5'd2, 5'd7, 1'b1, 32'h100, 32'h200), 32'h100, 32'h200, 1'b1);
        tick();
        issue(mk(32'h3004, 5'd6, 5'd7, 5'd8, 1'b0, 32'h6, 32'h7), 32'h6, 32'h7, 1'b0);
        @(negedge clk);
        chk("lu_ready_low", bus.id_ready, 0);
        tick();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_cnt", bus.bubble_cnt, 1);
        sb_q.push_back(mk(32'h3004, 5'd6, 5'd7, 5'd8, 1'b0, 32'h6, 32'h7));
        @(negedge clk);
        chk("lu_ready_high", bus.id_ready, 1);
        tick();
        chk("lu_accept", bus.ex_valid, 1);
        idle_in();
        tick();

        // Held operand picks up a writeback to its source register.
        issue(mk(32'h2000, 5'd9, 5'd0, 5'd3, 1'b0, 32'h55, 32'h0), 32'h10, 32'hDEAD, 1'b1);
        tick();
        bus.ex_ready = 1'b0;
        issue(mk(32'h2004, 5'd1, 5'd2, 5'd4, 1'b0, 32'h1, 32'h2), 32'h1, 32'h2, 1'b0);
        @(negedge clk);
        chk("hold_ready_low", bus.id_ready, 0);
        tick();
        chk("hold_op_a_pre", bus.ex_op_a, 32'h10);
        wb(1'b1, 5'd9, 32'h55);
        tick();
        chk("hold_op_a_wb", bus.ex_op_a, 32'h55);
        chk("hold_op_b", bus.ex_op_b, 0);
        chk("hold_pc", bus.ex_pc, 32'h2000);
        chk("hold_valid", bus.ex_valid, 1);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        chk("hold_op_a_keep", bus.ex_op_a, 32'h55);
        bus.ex_ready = 1'b1;
        sb_q.push_back(mk(32'h2004, 5'd1, 5'd2, 5'd4, 1'b0, 32'h1, 32'h2));
        tick();
        chk("hold_release_pc", bus.ex_pc, 32'h2004);
        idle_in();
        tick();

        // Flush beats the load-use bubble and discards the incoming instruction.
        issue(mk(32'h4000, 5'd1, 5'd2, 5'd7, 1'b1, 32'hA, 32'hB), 32'hA, 32'hB, 1'b1);
        tick();
        issue(mk(32'h4004, 5'd7, 5'd3, 5'd5, 1'b0, 32'h0, 32'h0), 32'h0, 32'h0, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_ready_formula", bus.id_ready, 0);
        tick();
        chk("fl_valid", bus.ex_valid, 0);
        chk("fl_bubble_cnt", bus.bubble_cnt, 1);
        issue(mk(32'h4008, 5'd1, 5'd2, 5'd5, 1'b0, 32'h0, 32'h0), 32'h0, 32'h0, 1'b0);
        tick();
        chk("fl_discard", bus.ex_valid, 0);
        idle_in();
        tick();

        // Full-throughput stream of independent instructions.
        for (int k = 0; k < 8; k++) begin
            issue(mk(32'h5000 + 32'(k) * 4, 5'(k + 1), 5'(k + 2), 5'(k + 20), 1'b0,
                     32'(k) * 16, 32'(k) * 16 + 1), 32'(k) * 16, 32'(k) * 16 + 1, 1'b1);
            tick();
            chk("stream_valid", bus.ex_valid, 1);
        end
        idle_in();
        tick();
        chk("stream_drain", bus.ex_valid, 0);

        // Reset during a stall drops the held instruction and clears the counter.
        issue(mk(32'h6000, 5'd1, 5'd2, 5'd3, 1'b0, 32'h1, 32'h2), 32'h1, 32'h2, 1'b1);
        tick();
        idle_in();
        bus.ex_ready = 1'b0;
        tick();
        chk("rs_stall_valid", bus.ex_valid, 1);
        rst = 1'b1;
        void'(sb_q.pop_back());
        tick();
        rst = 1'b0;
        chk("rs_valid", bus.ex_valid, 0);
        chk("rs_bubble", bus.bubble_cnt, 0);
        chk("rs_pc", bus.ex_pc, 0);
        idle_in();
        tick();
        tick();

        chk("sb_empty", 256'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
